// File: rtl/quad_demux_pkg.sv
// Shared defaults and slot-state encoding for the 1-to-2 handshake demultiplexer.
package quad_demux_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/quad_demux_1x2_if.sv
// Handshake bundle between a source, the demultiplexer and its two sinks.
interface quad_demux_1x2_if
    import quad_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [WIDTH-1:0] D;
    logic             in_valid;
    logic             in_ready;
    logic             G;
    logic             nEN;
    logic [WIDTH-1:0] YA;
    logic [WIDTH-1:0] YB;
    logic             a_valid;
    logic             b_valid;
    logic             a_ready;
    logic             b_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport slave (
        input  D, in_valid, G, nEN, a_ready, b_ready,
        output in_ready, YA, YB, a_valid, b_valid, cnt_a, cnt_b
    );

    modport master (
        output D, in_valid, G, nEN, a_ready, b_ready,
        input  in_ready, YA, YB, a_valid, b_valid, cnt_a, cnt_b
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry output buffer with valid/ready drain and a wrapping delivered-word counter.
module demux_slot
    import quad_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);
    slot_state_t      r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;

    assign w_pop = (r_state == FULL) && i_ready;

    // A push while draining refills the slot in place, so it stays FULL.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (i_push) begin
                r_state <= FULL;
                r_data  <= i_data;
            end else if (w_pop) begin
                r_state <= EMPTY;
            end
            if (w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/quad_demux_1x2.sv
// Steers each accepted word to slot A (G=0) or slot B (G=1); only the selected slot gates in_ready.
module quad_demux_1x2
    import quad_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              nRST,
    quad_demux_1x2_if.slave  bus
);
    logic [1:0]       w_valid;
    logic [1:0]       w_sink_ready;
    logic [1:0]       w_push;
    logic [WIDTH-1:0] w_data [2];
    logic [CNT_W-1:0] w_cnt  [2];
    logic             w_sel_free;
    logic             w_accept;

    assign w_sink_ready = {bus.b_ready, bus.a_ready};

    // The selected slot can take a word if empty or if it drains on the same edge.
    assign w_sel_free   = !w_valid[bus.G] || w_sink_ready[bus.G];
    assign bus.in_ready = nRST && !bus.nEN && w_sel_free;
    assign w_accept     = bus.in_valid && bus.in_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign w_push[gi] = w_accept && (bus.G == 1'(gi));

            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk     (clk),
                .nRST    (nRST),
                .i_push  (w_push[gi]),
                .i_data  (bus.D),
                .i_ready (w_sink_ready[gi]),
                .o_valid (w_valid[gi]),
                .o_data  (w_data[gi]),
                .o_cnt   (w_cnt[gi])
            );
        end
    endgenerate

    assign bus.a_valid = w_valid[0];
    assign bus.b_valid = w_valid[1];
    assign bus.YA      = w_data[0];
    assign bus.YB      = w_data[1];
    assign bus.cnt_a   = w_cnt[0];
    assign bus.cnt_b   = w_cnt[1];

endmodule

// File: tb/tb_quad_demux_1x2.sv
// Directed and randomized checks of quad_demux_1x2 against a per-channel occupancy model.
module tb_quad_demux_1x2;

    localparam int W  = 4;
    localparam int CW = 8;

    logic clk  = 1'b0;
    logic nRST = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: each channel holds at most one word; counts are plain integers reduced mod 2^CW.
    bit         m_full [2];
    logic [3:0] m_data [2];
    int         m_cnt  [2];

    quad_demux_1x2_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    quad_demux_1x2 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic m_ready_of(input int ch);
        return (ch == 0) ? bus.a_ready : bus.b_ready;
    endfunction

    function automatic logic m_in_ready();
        int sel;
        sel = bus.G ? 1 : 0;
        return nRST && !bus.nEN && (!m_full[sel] || m_ready_of(sel));
    endfunction

    function automatic logic [CW-1:0] m_count(input int ch);
        return CW'(m_cnt[ch] % (1 << CW));
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 0;
            m_data[c] = '0;
            m_cnt[c]  = 0;
        end
    endtask

    // Advance one clock edge, updating the model from the inputs presented before it.
    task automatic tick();
        bit acc;
        bit pop [2];
        int sel;
        acc = bus.in_valid && m_in_ready();
        sel = bus.G ? 1 : 0;
        for (int c = 0; c < 2; c++) pop[c] = m_full[c] && m_ready_of(c);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (pop[c]) begin
                m_cnt[c]++;
                m_full[c] = 0;
            end
        end
        if (acc) begin
            m_full[sel] = 1;
            m_data[sel] = bus.D;
            $display("xfer: D=%h -> ch%0d", bus.D, sel);
        end
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_clear();
        #3;
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.D = 4'hF; bus.in_valid = 1'b1; bus.G = 1'b0; bus.nEN = 1'b0;
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        model_clear();
        #2;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if ({bus.a_valid, bus.b_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", {bus.a_valid, bus.b_valid}); end
        total++; if ({bus.YA, bus.YB} !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", {bus.YA, bus.YB}); end
        total++; if ({bus.cnt_a, bus.cnt_b} !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", {bus.cnt_a, bus.cnt_b}); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.a_valid !== 1'b0) begin bad++; $display("FAIL post_reset_a_valid got=%b exp=0", bus.a_valid); end
    endtask

    task automatic test_basic();
        bus.D = 4'hA; bus.G = 1'b0; bus.nEN = 1'b0; bus.in_valid = 1'b1;
        bus.a_ready = 1'b1; bus.b_ready = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.a_valid !== 1'b1 || bus.YA !== 4'hA) begin bad++; $display("FAIL basic_deliver got=%b/%h exp=1/a", bus.a_valid, bus.YA); end
        total++; if (bus.b_valid !== 1'b0) begin bad++; $display("FAIL basic_b_idle got=%b exp=0", bus.b_valid); end
        tick();
        total++; if (bus.cnt_a !== 8'd1 || bus.a_valid !== 1'b0) begin bad++; $display("FAIL basic_cnt got=%0d/%b exp=1/0", bus.cnt_a, bus.a_valid); end
        total++; if (bus.b_valid !== 1'b0) begin bad++; $display("FAIL basic_b_still_idle got=%b exp=0", bus.b_valid); end
    endtask

    task automatic test_stall();
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        bus.D = 4'h3; bus.G = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.b_valid !== 1'b1 || bus.YB !== 4'h3) begin bad++; $display("FAIL stall_b_load got=%b/%h exp=1/3", bus.b_valid, bus.YB); end
        bus.D = 4'h7; bus.G = 1'b1; bus.in_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_blocked got=%b exp=0", bus.in_ready); end
        tick();
        total++; if (bus.YB !== 4'h3 || bus.b_valid !== 1'b1) begin bad++; $display("FAIL stall_stable got=%h/%b exp=3/1", bus.YB, bus.b_valid); end
        bus.D = 4'h9; bus.G = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_other_free got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.a_valid !== 1'b1 || bus.YA !== 4'h9 || bus.YB !== 4'h3) begin bad++; $display("FAIL stall_a_load got=%b/%h/%h exp=1/9/3", bus.a_valid, bus.YA, bus.YB); end
    endtask

    task automatic test_replace();
        bus.a_ready = 1'b1; bus.D = 4'h5; bus.G = 1'b0; bus.in_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL replace_in_ready got=%b exp=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.a_valid !== 1'b1 || bus.YA !== 4'h5) begin bad++; $display("FAIL replace_data got=%b/%h exp=1/5", bus.a_valid, bus.YA); end
        total++; if (bus.cnt_a !== 8'd2) begin bad++; $display("FAIL replace_cnt got=%0d exp=2", bus.cnt_a); end
        tick();
        total++; if (bus.a_valid !== 1'b0 || bus.cnt_a !== 8'd3) begin bad++; $display("FAIL replace_drain got=%b/%0d exp=0/3", bus.a_valid, bus.cnt_a); end
    endtask

    task automatic test_nen();
        bus.nEN = 1'b1; bus.b_ready = 1'b1; bus.G = 1'b1; bus.in_valid = 1'b1; bus.D = 4'hC;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL nen_block got=%b exp=0", bus.in_ready); end
        tick();
        total++; if (bus.b_valid !== 1'b0 || bus.cnt_b !== 8'd1) begin bad++; $display("FAIL nen_drain got=%b/%0d exp=0/1", bus.b_valid, bus.cnt_b); end
        bus.G = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL nen_block_a got=%b exp=0", bus.in_ready); end
        bus.nEN = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL nen_release got=%b exp=1", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.D        = 4'($urandom_range(0, 15));
            bus.G        = 1'($urandom_range(0, 1));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.nEN      = ($urandom_range(0, 7) == 0);
            bus.a_ready  = ($urandom_range(0, 2) != 0);
            bus.b_ready  = ($urandom_range(0, 2) != 0);
            #1;
            total++; if (bus.in_ready !== m_in_ready()) begin bad++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, bus.in_ready, m_in_ready()); end
            total++; if (bus.a_valid !== m_full[0] || bus.b_valid !== m_full[1]) begin bad++; $display("FAIL rand_valid i=%0d got=%b%b exp=%b%b", i, bus.a_valid, bus.b_valid, m_full[0], m_full[1]); end
            total++; if (bus.YA !== m_data[0] || bus.YB !== m_data[1]) begin bad++; $display("FAIL rand_data i=%0d got=%h%h exp=%h%h", i, bus.YA, bus.YB, m_data[0], m_data[1]); end
            total++; if (bus.cnt_a !== m_count(0) || bus.cnt_b !== m_count(1)) begin bad++; $display("FAIL rand_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, bus.cnt_a, bus.cnt_b, m_count(0), m_count(1)); end
            tick();
        end
        bus.in_valid = 1'b0; bus.nEN = 1'b0;
    endtask

    task automatic test_wrap();
        bus.in_valid = 1'b0; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        do_reset();
        bus.G = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.D = 4'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        total++; if (bus.cnt_a !== 8'd255) begin bad++; $display("FAIL wrap_pre got=%0d exp=255", bus.cnt_a); end
        tick();
        total++; if (bus.cnt_a !== 8'd0 || m_count(0) != 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", bus.cnt_a); end
        total++; if (bus.cnt_b !== 8'd0) begin bad++; $display("FAIL wrap_b_untouched got=%0d exp=0", bus.cnt_b); end
    endtask

    task automatic test_reset_mid();
        bus.a_ready = 1'b0; bus.b_ready = 1'b0; bus.in_valid = 1'b1;
        bus.G = 1'b0; bus.D = 4'h6; tick();
        bus.G = 1'b1; bus.D = 4'hD; tick();
        bus.in_valid = 1'b0;
        #1;
        total++; if ({bus.a_valid, bus.b_valid, bus.YA, bus.YB} !== {2'b11, 4'h6, 4'hD}) begin bad++; $display("FAIL mid_fill got=%b%b/%h%h exp=11/6d", bus.a_valid, bus.b_valid, bus.YA, bus.YB); end
        #1;
        nRST = 1'b0;
        model_clear();
        #1;
        total++; if ({bus.a_valid, bus.b_valid, bus.in_ready} !== 3'b000) begin bad++; $display("FAIL mid_async_valid got=%b exp=000", {bus.a_valid, bus.b_valid, bus.in_ready}); end
        total++; if ({bus.YA, bus.YB, bus.cnt_a, bus.cnt_b} !== 24'h0) begin bad++; $display("FAIL mid_async_data got=%h exp=0", {bus.YA, bus.YB, bus.cnt_a, bus.cnt_b}); end
        bus.a_ready = 1'b1; bus.b_ready = 1'b1;
        @(negedge clk);
        nRST = 1'b1;
        tick();
        tick();
        total++; if (bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0 || bus.a_valid !== 1'b0) begin bad++; $display("FAIL mid_no_deliver got=%0d/%0d/%b exp=0/0/0", bus.cnt_a, bus.cnt_b, bus.a_valid); end
    endtask

    initial begin
        bus.D = '0; bus.in_valid = 1'b0; bus.G = 1'b0; bus.nEN = 1'b0;
        bus.a_ready = 1'b0; bus.b_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_replace();
        test_nen();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
